// File: rtl/ship_life_ctl.sv
// ship_life_ctl: player ship lifecycle sequencer.
// Turns collision hits into a frame-timed DYING -> INVULN -> ALIVE sequence,
// counts lost lives and parks in GAME_OVER until the player restarts.
module ship_life_ctl #(
    parameter int LIVES         = 3,
    parameter int DEAD_FRAMES   = 60,
    parameter int INVULN_FRAMES = 90,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       hit,
    input  logic       restart,
    output logic [3:0] dead_count_out,
    output logic       ship_visible,
    output logic       dead_lock,
    output logic       collision_en,
    output logic       respawn,
    output logic       game_over
);

    typedef enum logic [1:0] {ALIVE, DYING, INVULN, GAME_OVER} state_t;

    localparam logic [3:0] LIVES_C    = 4'(LIVES);
    localparam logic [7:0] DEAD_LAST  = 8'(DEAD_FRAMES - 1);
    localparam logic [7:0] INV_LAST   = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t     state;
    logic       vsync_r;    // vsync_in captured once
    logic       vsync_q;    // previous captured value, for edge detect
    logic       tick;
    logic [7:0] frame_cnt;
    logic [7:0] blink_cnt;
    logic [3:0] dc_inc;

    // One tick per rising vsync edge, seen the cycle after vsync is captured.
    assign tick   = vsync_r & ~vsync_q;
    // Saturating increment so the count can never wrap past LIVES.
    assign dc_inc = (dead_count_out >= LIVES_C) ? dead_count_out : dead_count_out + 4'd1;

    // Capture vsync and keep one cycle of history for rising-edge detection.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_r <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            vsync_r <= vsync_in;
            vsync_q <= vsync_r;
        end
    end

    // Lifecycle FSM with registered outputs; respawn defaults low every cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state          <= ALIVE;
            dead_count_out <= 4'd0;
            ship_visible   <= 1'b1;
            dead_lock      <= 1'b0;
            collision_en   <= 1'b1;
            respawn        <= 1'b0;
            game_over      <= 1'b0;
            frame_cnt      <= 8'd0;
            blink_cnt      <= 8'd0;
        end else begin
            respawn <= 1'b0;
            case (state)
                ALIVE: begin
                    // A hit outranks a tick landing in the same cycle.
                    if (hit) begin
                        dead_count_out <= dc_inc;
                        frame_cnt      <= 8'd0;
                        ship_visible   <= 1'b0;
                        dead_lock      <= 1'b1;
                        collision_en   <= 1'b0;
                        if (dc_inc == LIVES_C) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= DYING;
                        end
                    end else if (tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                DYING: begin
                    if (tick) begin
                        if (frame_cnt == DEAD_LAST) begin
                            state        <= INVULN;
                            frame_cnt    <= 8'd0;
                            blink_cnt    <= 8'd0;
                            respawn      <= 1'b1;
                            ship_visible <= 1'b1;   // blink phase starts visible
                            dead_lock    <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                INVULN: begin
                    if (tick) begin
                        if (frame_cnt == INV_LAST) begin
                            // Exit overrides any blink toggle due on the same tick.
                            state        <= ALIVE;
                            frame_cnt    <= 8'd0;
                            ship_visible <= 1'b1;
                            collision_en <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                            if (blink_cnt == BLINK_LAST) begin
                                ship_visible <= ~ship_visible;
                                blink_cnt    <= 8'd0;
                            end else begin
                                blink_cnt <= blink_cnt + 8'd1;
                            end
                        end
                    end
                end
                GAME_OVER: begin
                    if (restart) begin
                        state          <= ALIVE;
                        dead_count_out <= 4'd0;
                        frame_cnt      <= 8'd0;
                        respawn        <= 1'b1;
                        ship_visible   <= 1'b1;
                        dead_lock      <= 1'b0;
                        collision_en   <= 1'b1;
                        game_over      <= 1'b0;
                    end
                end
                default: begin
                    state <= ALIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ship_life_ctl.sv
module tb_ship_life_ctl;

    logic       pclk;
    logic       rst;
    logic       vsync_in;
    logic       hit;
    logic       restart;
    logic [3:0] dead_count_out;
    logic       ship_visible;
    logic       dead_lock;
    logic       collision_en;
    logic       respawn;
    logic       game_over;

    ship_life_ctl #(
        .LIVES(3), .DEAD_FRAMES(4), .INVULN_FRAMES(6), .BLINK_FRAMES(2)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hit(hit), .restart(restart),
        .dead_count_out(dead_count_out), .ship_visible(ship_visible),
        .dead_lock(dead_lock), .collision_en(collision_en),
        .respawn(respawn), .game_over(game_over)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [3:0] dc;
        logic       vis;
        logic       lock;
        logic       coll;
        logic       resp;
        logic       go;
    } exp_t;

    typedef struct {
        logic  fr;
        logic  h;
        logic  r;
        logic  rs;
        exp_t  e;
        string nm;
    } vec_t;

    exp_t  sb[$];
    string nq[$];
    exp_t  last_e;
    vec_t  tbl[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic exp_t e_al(input logic [3:0] dc);
        return '{dc: dc, vis: 1'b1, lock: 1'b0, coll: 1'b1, resp: 1'b0, go: 1'b0};
    endfunction
    function automatic exp_t e_dy(input logic [3:0] dc);
        return '{dc: dc, vis: 1'b0, lock: 1'b1, coll: 1'b0, resp: 1'b0, go: 1'b0};
    endfunction
    function automatic exp_t e_inv(input logic [3:0] dc, input logic v, input logic r);
        return '{dc: dc, vis: v, lock: 1'b0, coll: 1'b0, resp: r, go: 1'b0};
    endfunction
    function automatic exp_t e_go(input logic [3:0] dc);
        return '{dc: dc, vis: 1'b0, lock: 1'b1, coll: 1'b0, resp: 1'b0, go: 1'b1};
    endfunction
    function automatic vec_t mk(input logic fr, input logic h, input logic r,
                                input logic rs, input exp_t e, input string nm);
        vec_t v;
        v.fr = fr; v.h = h; v.r = r; v.rs = rs; v.e = e; v.nm = nm;
        return v;
    endfunction

    task automatic step(input logic h, input logic r, input logic v, input logic rs,
                        input exp_t e, input string nm);
        @(negedge pclk);
        hit = h; restart = r; vsync_in = v; rst = rs;
        sb.push_back(e);
        nq.push_back(nm);
        last_e = e;
    endtask

    task automatic frame(input logic h, input exp_t e, input string nm);
        exp_t m;
        m = last_e;
        m.resp = 1'b0;
        step(h, 1'b0, 1'b1, 1'b0, m, {nm, "_mid"});
        step(h, 1'b0, 1'b0, 1'b0, e, nm);
    endtask

    task automatic chk_now(input exp_t ce, input string cn);
        exp_t act;
        act = {dead_count_out, ship_visible, dead_lock, collision_en, respawn, game_over};
        n_chk++;
        if (act === ce) n_pass++;
        else $display("FAIL %s: got dc=%0d vis=%b lock=%b coll=%b resp=%b go=%b, expected dc=%0d vis=%b lock=%b coll=%b resp=%b go=%b",
                      cn, act.dc, act.vis, act.lock, act.coll, act.resp, act.go,
                      ce.dc, ce.vis, ce.lock, ce.coll, ce.resp, ce.go);
    endtask

    always @(posedge pclk) begin
        exp_t  ce;
        exp_t  act;
        string cn;
        #1;
        if (sb.size() != 0) begin
            ce  = sb.pop_front();
            cn  = nq.pop_front();
            act = {dead_count_out, ship_visible, dead_lock, collision_en, respawn, game_over};
            n_chk++;
            if (act === ce) n_pass++;
            else $display("FAIL %s: got dc=%0d vis=%b lock=%b coll=%b resp=%b go=%b, expected dc=%0d vis=%b lock=%b coll=%b resp=%b go=%b",
                          cn, act.dc, act.vis, act.lock, act.coll, act.resp, act.go,
                          ce.dc, ce.vis, ce.lock, ce.coll, ce.resp, ce.go);
        end
    end

    initial begin
        rst = 1'b1; vsync_in = 1'b0; hit = 1'b0; restart = 1'b0;
        last_e = e_al(4'd0);

        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, e_dy(4'd1), "hit1"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "dy_t1"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "dy_t2"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "dy_t3"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b1), "dy_t4_respawn"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "respawn_drop"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "inv_t1"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b0, 1'b0), "inv_t2"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b0, 1'b0), "inv_t3"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "inv_t4"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "inv_t5"));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, e_al(4'd1), "inv_t6_alive"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd1), "alive_idle"));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, e_al(4'd0), "held_rst"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, e_dy(4'd1), "held_hit"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_dy(4'd1), "held_dy_t1"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_dy(4'd1), "held_dy_t2"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_dy(4'd1), "held_dy_t3"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b1), "held_dy_t4"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "held_inv_t1"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b0, 1'b0), "held_inv_t2"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b0, 1'b0), "held_inv_t3"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "held_inv_t4"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_inv(4'd1, 1'b1, 1'b0), "held_inv_t5"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, e_al(4'd1), "held_inv_t6"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, e_dy(4'd2), "held_second_hit"));

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, e_al(4'd0), "reset_hold");
        chk_now(e_al(4'd0), "reset_state");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd0), "reset_release");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].fr) frame(tbl[i].h, tbl[i].e, tbl[i].nm);
            else           step(tbl[i].h, tbl[i].r, 1'b0, tbl[i].rs, tbl[i].e, tbl[i].nm);
        end

        begin
            logic blk [5];
            blk = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 3; i++) frame(1'b0, e_dy(4'd2), "l2_dy");
            frame(1'b0, e_inv(4'd2, 1'b1, 1'b1), "l2_respawn");
            for (int i = 0; i < 5; i++) frame(1'b0, e_inv(4'd2, blk[i], 1'b0), "l2_blink");
            frame(1'b0, e_al(4'd2), "l2_alive");
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd2), "l2_idle");
        step(1'b1, 1'b0, 1'b0, 1'b0, e_go(4'd3), "third_hit_go");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_go(4'd3), "go_hold");
        for (int i = 0; i < 20; i++) frame(1'b1, e_go(4'd3), "go_frozen");

        step(1'b1, 1'b1, 1'b0, 1'b0, '{dc: 4'd0, vis: 1'b1, lock: 1'b0, coll: 1'b1, resp: 1'b1, go: 1'b0}, "restart");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd0), "restart_pulse_end");
        step(1'b0, 1'b1, 1'b0, 1'b0, e_al(4'd0), "restart_in_alive");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd0), "restart_in_alive2");

        step(1'b0, 1'b0, 1'b1, 1'b0, e_al(4'd0), "tick_capture");
        step(1'b1, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "hit_on_tick");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, e_dy(4'd1), "vsync_held");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "vsync_held_end");
        frame(1'b0, e_dy(4'd1), "hot_dy_t2");
        frame(1'b0, e_dy(4'd1), "hot_dy_t3");
        frame(1'b0, e_inv(4'd1, 1'b1, 1'b1), "hot_dy_t4");
        frame(1'b0, e_inv(4'd1, 1'b1, 1'b0), "hot_inv_t1");
        frame(1'b0, e_inv(4'd1, 1'b0, 1'b0), "hot_inv_t2");
        step(1'b1, 1'b1, 1'b0, 1'b1, e_al(4'd0), "rst_mid_inv");
        step(1'b0, 1'b0, 1'b0, 1'b0, e_al(4'd0), "rst_mid_inv_after");
        step(1'b1, 1'b0, 1'b0, 1'b0, e_dy(4'd1), "post_rst_hit");
        for (int i = 0; i < 3; i++) frame(1'b0, e_dy(4'd1), "post_rst_dy");
        frame(1'b0, e_inv(4'd1, 1'b1, 1'b1), "post_rst_respawn");

        @(negedge pclk);
        begin
          int w;
          w = 0;
          while (respawn !== 1'b0 && w < 8) begin
            @(negedge pclk);
            w++;
          end
          n_chk++;
          if (respawn === 1'b0) n_pass++;
          else $display("FAIL respawn_wait: respawn still high after %0d cycles", w);
        end
        chk_now(e_inv(4'd1, 1'b1, 1'b0), "final_inv_state");
        @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
